// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port of the fetch unit: valid/ready request channel plus
// a valid-only response channel, one request in flight at a time.
interface if_fetch_unit_if;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_req_addr;
    logic        im_resp_valid;
    logic [31:0] im_resp_data;

    modport master (
        output im_req_valid,
        output im_req_addr,
        input  im_req_ready,
        input  im_resp_valid,
        input  im_resp_data
    );

    modport slave (
        input  im_req_valid,
        input  im_req_addr,
        output im_req_ready,
        output im_resp_valid,
        output im_resp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC, single-outstanding instruction fetch, IF/ID register with a
// one-entry skid buffer, and redirect/flush handling for ID-resolved jumps.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] FLUSH_INST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IF_ID_write,
    input  logic            branch,
    input  logic [31:0]     branch_target,
    input  logic            jump_flag,
    input  logic [31:0]     jump_target,
    if_fetch_unit_if.master im,
    output logic [31:0]     instruction_o,
    output logic [31:0]     pc_o,
    output logic            inst_valid,
    output logic            IF_flush_out
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } entry_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    localparam entry_t EMPTY = '{inst: FLUSH_INST, pc: 32'h0, valid: 1'b0};

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    entry_t      out_q, out_d;
    entry_t      hold_q, hold_d;
    logic        flush_q, flush_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_fire;
    logic        resp_fire;
    entry_t      resp_entry;

    // Redirects are only meaningful while ID is advancing; jalr wins over branch.
    assign redirect    = IF_ID_write & (branch | jump_flag);
    assign redirect_pc = jump_flag ? jump_target : branch_target;
    assign resp_fire   = im.im_resp_valid & (state_q == S_WAIT);
    assign resp_entry  = '{inst: im.im_resp_data, pc: req_pc_q, valid: resp_fire};
    assign req_fire    = req_valid & im.im_req_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_REQ;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect)                state_d = im.im_resp_valid ? S_REQ : S_DROP;
                else if (im.im_resp_valid)   state_d = req_fire ? S_WAIT : S_REQ;
            end
            S_DROP: begin
                if (im.im_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // A back-to-back request in S_WAIT is only safe when the response just
    // returned goes straight to ID, leaving the hold buffer empty.
    always_comb begin
        req_valid = 1'b0;
        case (state_q)
            S_REQ:   req_valid = ~hold_q.valid & ~redirect;
            S_WAIT:  req_valid = im.im_resp_valid & IF_ID_write & ~hold_q.valid & ~redirect;
            default: req_valid = 1'b0;
        endcase
        if (rst) req_valid = 1'b0;
    end

    assign im.im_req_valid = req_valid;
    assign im.im_req_addr  = {fetch_pc_q[31:2], 2'b00};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        out_d      = out_q;
        hold_d     = hold_q;
        flush_d    = 1'b0;

        if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect && state_q != S_DROP) begin
            fetch_pc_d = redirect_pc;
            out_d      = EMPTY;
            hold_d     = EMPTY;
            flush_d    = 1'b1;
        end else begin
            if (redirect) fetch_pc_d = redirect_pc;
            if (IF_ID_write) begin
                if (hold_q.valid) begin
                    out_d  = hold_q;
                    hold_d = resp_fire ? resp_entry : EMPTY;
                end else if (resp_fire) begin
                    out_d  = resp_entry;
                end else begin
                    out_d  = EMPTY;
                end
            end else if (resp_fire) begin
                hold_d = resp_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            out_q      <= EMPTY;
            hold_q     <= EMPTY;
            flush_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            out_q      <= out_d;
            hold_q     <= hold_d;
            flush_q    <= flush_d;
        end
    end

    assign instruction_o = out_q.inst;
    assign pc_o          = out_q.pc;
    assign inst_valid    = out_q.valid;
    assign IF_flush_out  = flush_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder, in-order stream scoreboard,
// a redirect vector table, directed corner sequences and a random soak.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] FLUSH_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr  = 1'b1;
    logic        br  = 1'b0;
    logic        jf  = 1'b0;
    logic [31:0] bt  = '0;
    logic [31:0] jt  = '0;
    logic [31:0] instruction_o, pc_o;
    logic        inst_valid, IF_flush_out;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(RESET_PC), .FLUSH_INST(FLUSH_INST)) dut (
        .clk          (clk),
        .rst          (rst),
        .IF_ID_write  (wr),
        .branch       (br),
        .branch_target(bt),
        .jump_flag    (jf),
        .jump_target  (jt),
        .im           (bus),
        .instruction_o(instruction_o),
        .pc_o         (pc_o),
        .inst_valid   (inst_valid),
        .IF_flush_out (IF_flush_out)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // memory model state
    int          lat       = 1;
    bit          rnd_ready = 1'b0;
    bit          pend      = 1'b0;
    bit          own       = 1'b0;
    int          cnt       = 0;
    logic [31:0] maddr     = '0;
    bit          last_acc  = 1'b0;
    logic [31:0] last_acc_addr = '0;

    // stream reference model
    bit          armed     = 1'b0;
    bit          prev_rst  = 1'b0;
    bit          drop      = 1'b0;
    bit          exp_flush = 1'b0;
    logic [31:0] exp_pc    = RESET_PC;
    int          n_cons    = 0;

    typedef struct {
        logic        wr, br, jf;
        logic [31:0] bt, jt;
        logic        exp_flush;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        bit redir, resp_now;
        if (armed && prev_rst) begin
            chk("rst_valid", {31'b0, inst_valid}, 32'd0);
            chk("rst_inst", instruction_o, FLUSH_INST);
            chk("rst_pc", pc_o, 32'h0);
            chk("rst_flush", {31'b0, IF_flush_out}, 32'd0);
        end else if (armed) begin
            chk("flush", {31'b0, IF_flush_out}, {31'b0, exp_flush});
            if (exp_flush) chk("flush_invalid", {31'b0, inst_valid}, 32'd0);
            if (inst_valid) begin
                chk("held_pc", pc_o, exp_pc);
                chk("held_inst", instruction_o, mdata(pc_o));
            end
        end
        bus.im_resp_valid = 1'b0;
        bus.im_resp_data  = '0;
        if (pend) begin
            if (cnt <= 1) begin
                bus.im_resp_valid = 1'b1;
                bus.im_resp_data  = mdata(maddr);
            end else cnt--;
        end
        bus.im_req_ready = (!rnd_ready || $urandom_range(0, 3) != 0) && (!pend || bus.im_resp_valid);
        #1;
        redir    = !rst && wr && (br || jf);
        resp_now = bus.im_resp_valid;
        if (rst)        chk("req_in_rst", {31'b0, bus.im_req_valid}, 32'd0);
        else if (redir) chk("req_on_redirect", {31'b0, bus.im_req_valid}, 32'd0);
        if (!rst && armed && wr && inst_valid) begin
            exp_pc = exp_pc + 32'd4;
            n_cons++;
        end
        last_acc      = bus.im_req_valid && bus.im_req_ready;
        last_acc_addr = bus.im_req_addr;
        exp_flush     = redir && !drop;
        if (rst) begin
            exp_pc = RESET_PC;
            drop   = 1'b0;
        end else begin
            if (drop) begin
                if (resp_now) drop = 1'b0;
            end else if (redir) drop = own && !resp_now;
            if (redir) exp_pc = jf ? jt : bt;
        end
        if (resp_now) begin pend = 1'b0; own = 1'b0; end
        if (last_acc) begin pend = 1'b1; own = 1'b1; maddr = last_acc_addr; cnt = lat; end
        if (rst) begin own = 1'b0; armed = 1'b1; end
        prev_rst = rst;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b1; br = 1'b0; jf = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_pc(input logic [31:0] a, input string nm);
        int k = 0;
        while (!(inst_valid === 1'b1 && pc_o === a) && k < 200) begin
            step();
            k++;
        end
        chk(nm, pc_o, a);
    endtask

    initial begin
        int k, bad;
        logic [31:0] stale;
        bus.im_req_ready  = 1'b0;
        bus.im_resp_valid = 1'b0;
        bus.im_resp_data  = '0;

        //            wr    br    jf    bt             jt            flush  next pc
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h100,       32'h0,        1'b1, 32'h100};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'h200,      1'b1, 32'h200};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h100,       32'h200,      1'b1, 32'h200};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h100,       32'h200,      1'b0, 32'h00C};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h100,       32'h200,      1'b0, 32'h00C};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        1'b1, 32'hFFFF_FFFC};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h100,       32'h0,        1'b0, 32'h00C};

        @(negedge clk);

        // Streaming start-up: back-to-back requests, first valid two cycles in.
        lat = 1;
        do_reset();
        step(); chk("a_req0", {31'b0, last_acc}, 32'd1); chk("a_addr0", last_acc_addr, 32'h0);
        chk("a_v1", {31'b0, inst_valid}, 32'd0);
        step(); chk("a_addr1", last_acc_addr, 32'h4);
        chk("a_v2", {31'b0, inst_valid}, 32'd1); chk("a_pc0", pc_o, 32'h0);
        step(); chk("a_addr2", last_acc_addr, 32'h8); chk("a_pc4", pc_o, 32'h4);
        step(); chk("a_addr3", last_acc_addr, 32'hC); chk("a_pc8", pc_o, 32'h8);
        chk("a_inst8", instruction_o, mdata(32'h8));

        // Three-cycle stall: frozen output, no request while the hold buffer is full.
        wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_stall_pc", pc_o, 32'h8);
            chk("b_no_req", {31'b0, last_acc}, 32'd0);
        end
        wr = 1'b1;
        step(); chk("b_release_pc", pc_o, 32'hC); chk("b_release_v", {31'b0, inst_valid}, 32'd1);
        run_until_pc(32'h10, "b_next_pc");

        // Redirect vector table from a fixed streaming point.
        for (int v = 0; v < 7; v++) begin
            lat = 1;
            do_reset();
            run_until_pc(32'h8, "t_reach8");
            wr = tbl[v].wr; br = tbl[v].br; jf = tbl[v].jf; bt = tbl[v].bt; jt = tbl[v].jt;
            step();
            wr = 1'b1; br = 1'b0; jf = 1'b0;
            chk($sformatf("t%0d_flush", v), {31'b0, IF_flush_out}, {31'b0, tbl[v].exp_flush});
            k = 0;
            while (!(inst_valid && pc_o != 32'h8) && k < 50) begin step(); k++; end
            chk($sformatf("t%0d_next_pc", v), pc_o, tbl[v].exp_pc);
            if (v == 5) run_until_pc(32'h0, "t_wrap_pc");
        end

        // Branch while a slow fetch of 0x10 is in flight.
        lat = 3;
        do_reset();
        k = 0;
        do begin step(); k++; end while (!(last_acc && last_acc_addr == 32'h10) && k < 100);
        chk("c_acc10", last_acc_addr, 32'h10);
        br = 1'b1; bt = 32'h100;
        step();
        br = 1'b0;
        chk("c_flush1", {31'b0, IF_flush_out}, 32'd1);
        chk("c_flush_inv", {31'b0, inst_valid}, 32'd0);
        bad = 0;
        step();
        chk("c_flush0", {31'b0, IF_flush_out}, 32'd0);
        k = 0;
        while (!last_acc && k < 50) begin step(); k++; if (inst_valid && pc_o == 32'h10) bad++; end
        chk("c_next_req", last_acc_addr, 32'h100);
        for (int i = 0; i < 12; i++) begin step(); if (inst_valid && pc_o == 32'h10) bad++; end
        chk("c_no_stale", bad, 0);

        // Reset while waiting; the abandoned response lands two cycles after release.
        lat = 1;
        do_reset();
        run_until_pc(32'h8, "f_reach8");
        lat = 4;
        k = 0;
        do begin step(); k++; end while (!last_acc && k < 20);
        stale = last_acc_addr;
        chk("f_stale_nonzero", {31'b0, stale != RESET_PC}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); chk("f_v_r1", {31'b0, inst_valid}, 32'd0); chk("f_noacc_r1", {31'b0, last_acc}, 32'd0);
        step(); chk("f_v_r2", {31'b0, inst_valid}, 32'd0); chk("f_inst_r2", instruction_o, FLUSH_INST);
        lat = 1;
        step(); chk("f_first_req", {31'b0, last_acc}, 32'd1); chk("f_first_addr", last_acc_addr, RESET_PC);
        chk("f_v_r3", {31'b0, inst_valid}, 32'd0);
        step(); chk("f_pc0", pc_o, RESET_PC); chk("f_inst0", instruction_o, mdata(RESET_PC));
        chk("f_v_r4", {31'b0, inst_valid}, 32'd1);

        // Random soak against the stream model.
        do_reset();
        rnd_ready = 1'b1;
        n_cons = 0;
        for (int i = 0; i < 4000; i++) begin
            wr  = ($urandom_range(0, 4) != 0);
            br  = ($urandom_range(0, 19) == 0);
            jf  = ($urandom_range(0, 29) == 0);
            bt  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            jt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            lat = $urandom_range(1, 3);
            step();
        end
        wr = 1'b1; br = 1'b0; jf = 1'b0;
        chk("r_progress", {31'b0, n_cons > 300}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
